// File: rtl/input_sync_debounce.sv
// input_sync_debounce: multi-flop synchronizer followed by a counting debouncer.
// Optional glitch counter is built when INPUT_SYNC_DEBOUNCE_GLITCH_COUNT_EN is defined.
module input_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit INITIAL_LEVEL   = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_en,
    input  logic       in,
    output logic       out
`ifdef INPUT_SYNC_DEBOUNCE_GLITCH_COUNT_EN
    ,
    output logic [7:0] glitch_count
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {STABLE, PENDING} state_t;

    logic [SYNC_STAGES-1:0] chain = {SYNC_STAGES{INITIAL_LEVEL}};
    logic                   sync;

    state_t        state = STABLE;
    state_t        state_nxt;
    logic [CW-1:0] cnt = '0;
    logic [CW-1:0] cnt_nxt;
    logic          out_q = INITIAL_LEVEL;
    logic          out_nxt;

    assign sync = chain[SYNC_STAGES-1];
    assign out  = out_q;

    // The synchronizer runs every cycle; only the debouncer honours clk_en.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain <= {SYNC_STAGES{INITIAL_LEVEL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], in};
        end
    end

`ifdef INPUT_SYNC_DEBOUNCE_GLITCH_COUNT_EN
    logic       glitch;
    logic [7:0] gcnt = '0;
    logic [7:0] gcnt_nxt;

    assign glitch_count = gcnt;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = out_q;
`ifdef INPUT_SYNC_DEBOUNCE_GLITCH_COUNT_EN
        glitch    = 1'b0;
`endif
        if (clk_en) begin
            if (sync != out_q) begin
                if (cnt == LAST) begin
                    out_nxt   = sync;
                    cnt_nxt   = '0;
                    state_nxt = STABLE;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                    state_nxt = PENDING;
                end
            end else begin
                cnt_nxt   = '0;
                state_nxt = STABLE;
`ifdef INPUT_SYNC_DEBOUNCE_GLITCH_COUNT_EN
                glitch    = (state == PENDING);
`endif
            end
        end
    end

`ifdef INPUT_SYNC_DEBOUNCE_GLITCH_COUNT_EN
    // Saturating: the count sticks at 255 rather than wrapping.
    always_comb begin
        gcnt_nxt = gcnt;
        if (glitch && gcnt != 8'hFF) begin
            gcnt_nxt = gcnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gcnt <= '0;
        end else begin
            gcnt <= gcnt_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= STABLE;
            cnt   <= '0;
            out_q <= INITIAL_LEVEL;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            out_q <= out_nxt;
        end
    end

endmodule

// File: tb/tb_input_sync_debounce.sv
// Bench for input_sync_debounce: directed latency/glitch cases plus random
// stimulus, all checked against a behavioural model on every cycle.
module tb_input_sync_debounce;

    logic clk = 1'b0;
    logic reset_n;
    logic clk_en;
    logic in;
    logic o0;
    logic o1;
    logic [7:0] g0;
    logic [7:0] g1;

    int vectors = 0;
    int miscompares = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    input_sync_debounce #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .INITIAL_LEVEL(1'b0)
    ) u0 (
        .clk(clk),
        .reset_n(reset_n),
        .clk_en(clk_en),
        .in(in),
        .out(o0)
`ifdef INPUT_SYNC_DEBOUNCE_GLITCH_COUNT_EN
        ,
        .glitch_count(g0)
`endif
    );

    input_sync_debounce #(
        .SYNC_STAGES(3),
        .DEBOUNCE_CYCLES(1),
        .INITIAL_LEVEL(1'b1)
    ) u1 (
        .clk(clk),
        .reset_n(reset_n),
        .clk_en(clk_en),
        .in(in),
        .out(o1)
`ifdef INPUT_SYNC_DEBOUNCE_GLITCH_COUNT_EN
        ,
        .glitch_count(g1)
`endif
    );

`ifndef INPUT_SYNC_DEBOUNCE_GLITCH_COUNT_EN
    assign g0 = 8'd0;
    assign g1 = 8'd0;
`endif

    // Behavioural model: sync is `in` delayed S edges; out flips once the
    // new level has been seen on D consecutive enabled edges.
    int ms [2] = '{2, 3};
    int md [2] = '{4, 1};
    bit mil [2] = '{1'b0, 1'b1};
    bit m_hist [2][4];
    bit m_out [2];
    int m_run [2];
    int m_gl [2];

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!reset_n) begin
                for (int j = 0; j < 4; j++) m_hist[u][j] = mil[u];
                m_out[u] = mil[u];
                m_run[u] = 0;
                m_gl[u] = 0;
            end else begin
                bit s;
                s = m_hist[u][ms[u]-1];
                if (clk_en) begin
                    if (s != m_out[u]) begin
                        m_run[u]++;
                        if (m_run[u] == md[u]) begin
                            m_out[u] = s;
                            m_run[u] = 0;
                        end
                    end else begin
                        if (m_run[u] > 0 && m_gl[u] < 255) m_gl[u]++;
                        m_run[u] = 0;
                    end
                end
                for (int j = 3; j > 0; j--) m_hist[u][j] = m_hist[u][j-1];
                m_hist[u][0] = in;
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("out_u0", int'(o0), int'(m_out[0]));
            check("out_u1", int'(o1), int'(m_out[1]));
`ifdef INPUT_SYNC_DEBOUNCE_GLITCH_COUNT_EN
            check("glitch_u0", int'(g0), m_gl[0]);
            check("glitch_u1", int'(g1), m_gl[1]);
`endif
        end
    end

    task automatic count_edges(input bit target, input int exp, input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (o0 !== target && n < 40);
        check(nm, n, exp);
    endtask

    task automatic check_glitch(input string nm, input int exp);
`ifdef INPUT_SYNC_DEBOUNCE_GLITCH_COUNT_EN
        check(nm, int'(g0), exp);
`endif
    endtask

    initial begin
        int rise;
        int fall;
        int moved;
        int hold;

        reset_n = 1'b0;
        clk_en = 1'b1;
        in = 1'b1;
        @(posedge clk);
        armed = 1'b1;

        // Reset held with in=1: out stays low, then full latency after release
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("rst_out", int'(o0), 0);
            check_glitch("rst_glitch", 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        count_edges(1'b1, 6, "rst_release_latency");

        // Clean steps
        @(negedge clk);
        in = 1'b0;
        count_edges(1'b0, 6, "step_fall_latency");
        @(negedge clk);
        in = 1'b1;
        count_edges(1'b1, 6, "step_rise_latency");
        @(negedge clk);
        in = 1'b0;
        count_edges(1'b0, 6, "step_fall2_latency");
        check_glitch("step_glitch", 0);

        // Three-cycle pulse is rejected
        @(negedge clk);
        in = 1'b1;
        repeat (3) @(negedge clk);
        in = 1'b0;
        moved = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (o0 !== 1'b0) moved++;
        end
        check("glitch3_out_moves", moved, 0);
        check_glitch("glitch3_count", 1);

        // Four-cycle pulse passes through
        rise = 0;
        fall = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            in = (k <= 4);
            @(posedge clk);
            #1;
            if (o0 && rise == 0) rise = k;
            if (!o0 && rise != 0 && fall == 0) fall = k;
        end
        check("pulse4_rise_edge", rise, 6);
        check("pulse4_fall_edge", fall, 10);
        check_glitch("pulse4_count", 1);

        // Enable on one edge in four
        rise = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            in = 1'b1;
            clk_en = (k % 4 == 0);
            @(posedge clk);
            #1;
            if (o0 && rise == 0) rise = k;
        end
        check("gated_rise_edge", rise, 16);
        @(negedge clk);
        clk_en = 1'b1;
        in = 1'b0;
        count_edges(1'b0, 6, "gated_restore_fall");

        // Reset in the middle of a pending change
        @(negedge clk);
        in = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out", int'(o0), 0);
        check_glitch("midrst_glitch", 0);
        @(negedge clk);
        reset_n = 1'b1;
        count_edges(1'b1, 6, "midrst_latency");
        @(negedge clk);
        in = 1'b0;
        count_edges(1'b0, 6, "midrst_fall");

        // Saturation with 300 rejected pulses
        moved = 0;
        for (int p = 0; p < 300; p++) begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                in = (k < 3);
                @(posedge clk);
                #1;
                if (o0 !== 1'b0) moved++;
            end
        end
        repeat (6) begin
            @(posedge clk);
            #1;
            if (o0 !== 1'b0) moved++;
        end
        check("sat_out_moves", moved, 0);
        check_glitch("sat_count", 255);

        // Random in, enable and occasional reset
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (hold == 0) begin
                in = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 12);
            end
            hold--;
            clk_en = ($urandom_range(0, 3) != 0);
            reset_n = ($urandom_range(0, 149) != 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        clk_en = 1'b1;
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
